bin_decode_engine: RTL and testbench

Arithmetic-decoding core for the VVC CABAC path: holds the 9-bit interval range and offset and turns each bin request into a decoded bin. Decision bins use the LPS sub-range supplied by the LPS-computation stage. Bypass bins need no LPS. After each decision the block renormalises one bitstream bit per cycle. It sits directly downstream of the LPS stage: it drives that stage's range input, takes its `lps` result back, and feeds decoded bins to the context-update and syntax logic.

---
 rtl/bin_decode_engine_pkg.sv | 16 +
 rtl/bin_decode_engine.sv | 121 ++++++++++++
 tb/tb_bin_decode_engine.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bin_decode_engine_pkg.sv
// bin_decode_engine_pkg: shared CABAC decoder states and interval constants
package bin_decode_engine_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INIT,
        READY,
        RENORM,
        BYPASS
    } engine_state_t;

    localparam int RANGE_INIT    = 510;
    localparam int RENORM_THRESH = 256;
    localparam int OFFSET_MAX    = 510;

endpackage

// File: rtl/bin_decode_engine.sv
// bin_decode_engine: CABAC arithmetic decoder holding range/offset and producing decoded bins
module bin_decode_engine
    import bin_decode_engine_pkg::*;
#(
    parameter int RANGE_W = 9,
    parameter int LPS_W   = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               init_start,
    input  logic               bin_req_valid,
    output logic               bin_req_ready,
    input  logic               req_bypass,
    input  logic               req_mps,
    output logic [RANGE_W-1:0] range_out,
    input  logic [LPS_W-1:0]   lps_in,
    input  logic               bit_valid,
    input  logic               bit_in,
    output logic               bit_ready,
    output logic               bin_valid,
    output logic               bin_out,
    output logic               bin_is_lps,
    output logic               err
);

    engine_state_t      state, state_n;
    logic [RANGE_W-1:0] range_q, range_n, offset_q, offset_n;
    logic [3:0]         cnt, cnt_n;
    logic               err_n, bin_valid_n, bin_out_n, bin_is_lps_n;
    logic [RANGE_W-1:0] lps_ext, r_mps, shift_off, range_sh;
    logic [RANGE_W:0]   t, t_sub;

    assign lps_ext       = {{(RANGE_W-LPS_W){1'b0}}, lps_in};
    assign r_mps         = range_q - lps_ext;
    assign shift_off     = {offset_q[RANGE_W-2:0], bit_in};
    assign range_sh      = {range_q[RANGE_W-2:0], 1'b0};
    assign t             = {offset_q, bit_in};
    assign t_sub         = t - {1'b0, range_q};
    assign range_out     = range_q;
    assign bin_req_ready = (state == READY);
    assign bit_ready     = (state == INIT) || (state == RENORM) || (state == BYPASS);

    // state and datapath registers; init_start and reset take precedence in next-state logic
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            range_q    <= RANGE_W'(RANGE_INIT);
            offset_q   <= '0;
            cnt        <= '0;
            err        <= 1'b0;
            bin_valid  <= 1'b0;
            bin_out    <= 1'b0;
            bin_is_lps <= 1'b0;
        end else begin
            state      <= state_n;
            range_q    <= range_n;
            offset_q   <= offset_n;
            cnt        <= cnt_n;
            err        <= err_n;
            bin_valid  <= bin_valid_n;
            bin_out    <= bin_out_n;
            bin_is_lps <= bin_is_lps_n;
        end
    end

    // next-state: init load, decision split, renormalisation shifts and bypass compare
    always_comb begin
        state_n      = state;
        range_n      = range_q;
        offset_n     = offset_q;
        cnt_n        = cnt;
        err_n        = err;
        bin_valid_n  = 1'b0;
        bin_out_n    = bin_out;
        bin_is_lps_n = bin_is_lps;
        if (init_start) begin
            state_n  = INIT;
            range_n  = RANGE_W'(RANGE_INIT);
            offset_n = '0;
            cnt_n    = '0;
            err_n    = 1'b0;
        end else begin
            case (state)
                INIT: if (bit_valid) begin
                    offset_n = shift_off;
                    cnt_n    = cnt + 4'd1;
                    if (cnt == 4'd8) begin
                        state_n = READY;
                        err_n   = err | (shift_off >= RANGE_W'(OFFSET_MAX));
                    end
                end
                READY: if (bin_req_valid) begin
                    if (req_bypass) begin
                        state_n = BYPASS;
                    end else begin
                        bin_valid_n  = 1'b1;
                        bin_is_lps_n = offset_q >= r_mps;
                        bin_out_n    = bin_is_lps_n ? !req_mps : req_mps;
                        offset_n     = bin_is_lps_n ? offset_q - r_mps : offset_q;
                        range_n      = bin_is_lps_n ? lps_ext : r_mps;
                        state_n      = (range_n < RANGE_W'(RENORM_THRESH)) ? RENORM : READY;
                    end
                end
                RENORM: if (bit_valid) begin
                    range_n  = range_sh;
                    offset_n = shift_off;
                    state_n  = (range_sh >= RANGE_W'(RENORM_THRESH)) ? READY : RENORM;
                end
                BYPASS: if (bit_valid) begin
                    bin_valid_n  = 1'b1;
                    bin_is_lps_n = 1'b0;
                    bin_out_n    = t >= {1'b0, range_q};
                    offset_n     = bin_out_n ? t_sub[RANGE_W-1:0] : t[RANGE_W-1:0];
                    state_n      = READY;
                end
                default: state_n = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bin_decode_engine.sv
// tb_bin_decode_engine: scoreboard bench with an integer interval model of the CABAC decoder
module tb_bin_decode_engine;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       init_start = 1'b0;
    logic       bin_req_valid = 1'b0;
    logic       bin_req_ready;
    logic       req_bypass = 1'b0;
    logic       req_mps = 1'b0;
    logic [8:0] range_out;
    logic [7:0] lps_in = '0;
    logic       bit_valid = 1'b0;
    logic       bit_in = 1'b0;
    logic       bit_ready;
    logic       bin_valid;
    logic       bin_out;
    logic       bin_is_lps;
    logic       err;

    int tests = 0;
    int fails = 0;
    int exp_q[$];
    int m_range = 510;
    int m_off = 0;
    int stall_max = 0;

    bin_decode_engine dut (
        .clk(clk), .rst(rst), .init_start(init_start),
        .bin_req_valid(bin_req_valid), .bin_req_ready(bin_req_ready),
        .req_bypass(req_bypass), .req_mps(req_mps),
        .range_out(range_out), .lps_in(lps_in),
        .bit_valid(bit_valid), .bit_in(bit_in), .bit_ready(bit_ready),
        .bin_valid(bin_valid), .bin_out(bin_out), .bin_is_lps(bin_is_lps), .err(err)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // monitor: every bin_valid pulse must match the oldest expected bin (value*2 + lps flag)
    always @(negedge clk) begin
        if (bin_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_bin_valid: bin_valid=%0d with no pending bin, required 0", bin_valid);
            end else begin
                chk("bin", {bin_out, bin_is_lps}, exp_q.pop_front());
            end
        end
    end

    task automatic feed_bit(input logic b);
        bit_valid = 1'b0;
        repeat ($urandom_range(0, stall_max)) tick();
        chk("bit_ready", bit_ready, 1);
        bit_valid = 1'b1;
        bit_in = b;
        tick();
        bit_valid = 1'b0;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!bin_req_ready) begin
            if (n == 50) begin
                chk("wait_ready_timeout", bin_req_ready, 1);
                return;
            end
            tick();
            n++;
        end
    endtask

    task automatic start_init();
        init_start = 1'b1;
        tick();
        init_start = 1'b0;
        chk("init_range", range_out, 510);
        chk("init_bit_ready", bit_ready, 1);
        chk("init_req_ready", bin_req_ready, 0);
        chk("init_err_clear", err, 0);
    endtask

    task automatic init_bits(input logic [8:0] v);
        for (int i = 8; i >= 0; i--) begin
            if (i == 0) chk("init_not_ready_yet", bin_req_ready, 0);
            feed_bit(v[i]);
        end
        m_range = 510;
        m_off = int'(v);
        chk("init_ready", bin_req_ready, 1);
        chk("init_err", err, int'(v >= 9'd510));
        chk("init_range_done", range_out, 510);
    endtask

    task automatic do_init(input logic [8:0] v);
        start_init();
        init_bits(v);
    endtask

    task automatic do_dec(input logic mps, input int lps, input int max_bits);
        int rmps;
        int nb = 0;
        logic [7:0] l;
        logic b;
        wait_ready();
        chk("dec_range_out", range_out, m_range);
        l = lps[7:0];
        bin_req_valid = 1'b1;
        req_bypass = 1'b0;
        req_mps = mps;
        lps_in = l;
        rmps = m_range - lps;
        if (m_off >= rmps) begin
            m_off = m_off - rmps;
            m_range = lps;
            exp_q.push_back((mps ? 0 : 2) + 1);
        end else begin
            m_range = rmps;
            exp_q.push_back(mps ? 2 : 0);
        end
        tick();
        bin_req_valid = 1'b0;
        lps_in = $urandom;
        chk("dec_ready_after", bin_req_ready, int'(m_range >= 256));
        while (m_range < 256 && nb < max_bits) begin
            b = 1'($urandom);
            feed_bit(b);
            m_range = m_range * 2;
            m_off = m_off * 2 + int'(b);
            nb++;
        end
        if (m_range >= 256) begin
            chk("dec_ready_final", bin_req_ready, 1);
            chk("dec_range_final", range_out, m_range);
        end
    endtask

    task automatic do_bypass();
        int tv;
        logic b;
        wait_ready();
        bin_req_valid = 1'b1;
        req_bypass = 1'b1;
        tick();
        bin_req_valid = 1'b0;
        req_bypass = 1'b0;
        chk("byp_req_ready", bin_req_ready, 0);
        b = 1'($urandom);
        tv = 2 * m_off + int'(b);
        if (tv >= m_range) begin
            m_off = tv - m_range;
            exp_q.push_back(2);
        end else begin
            m_off = tv;
            exp_q.push_back(0);
        end
        feed_bit(b);
        chk("byp_ready", bin_req_ready, 1);
        chk("byp_range", range_out, m_range);
    endtask

    initial begin
        int r;
        logic [8:0] v;
        repeat (2) tick();
        chk("rst_range", range_out, 510);
        chk("rst_req_ready", bin_req_ready, 0);
        chk("rst_bit_ready", bit_ready, 0);
        chk("rst_bin_valid", bin_valid, 0);
        chk("rst_bin_out", bin_out, 0);
        chk("rst_bin_is_lps", bin_is_lps, 0);
        chk("rst_err", err, 0);
        rst = 1'b0;
        tick();
        chk("idle_req_ready", bin_req_ready, 0);

        do_init(9'd1);
        do_dec(1'b1, 20, 8);
        chk("mps_range_490", range_out, 490);
        do_dec(1'b0, 100, 8);

        do_init(9'd500);
        do_dec(1'b1, 20, 8);
        chk("lps_renorm_range", m_range, 320);
        do_bypass();
        do_bypass();

        do_init(9'd500);
        do_dec(1'b1, 20, 0);
        chk("renorm_entry_range", range_out, 20);
        bit_valid = 1'b0;
        repeat (5) begin
            tick();
            chk("stall_range", range_out, 20);
            chk("stall_req_ready", bin_req_ready, 0);
        end
        feed_bit(1'b1);
        chk("renorm_step_range", range_out, 40);
        do_init(9'd300);
        do_dec(1'b1, 200, 8);

        wait_ready();
        bin_req_valid = 1'b1;
        req_bypass = 1'b1;
        tick();
        bin_req_valid = 1'b0;
        req_bypass = 1'b0;
        do_init(9'd77);
        do_bypass();

        wait_ready();
        init_start = 1'b1;
        bin_req_valid = 1'b1;
        lps_in = 8'd30;
        tick();
        init_start = 1'b0;
        bin_req_valid = 1'b0;
        chk("init_over_req_ready", bin_req_ready, 0);
        chk("init_over_bit_ready", bit_ready, 1);
        chk("init_over_range", range_out, 510);
        init_bits(9'd250);
        do_dec(1'b0, 60, 8);

        do_init(9'h1FF);
        repeat (3) tick();
        chk("err_sticky", err, 1);
        do_init(9'd10);
        do_init(9'h1FF);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_mid_err", err, 0);
        chk("rst_mid_req_ready", bin_req_ready, 0);

        do_init(9'd500);
        do_dec(1'b0, 20, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst2_range", range_out, 510);
        chk("rst2_bit_ready", bit_ready, 0);
        chk("rst2_bin_out", bin_out, 0);
        chk("rst2_bin_is_lps", bin_is_lps, 0);
        chk("rst2_bin_valid", bin_valid, 0);

        stall_max = 2;
        do_init(9'(($urandom_range(0, 509))));
        for (int i = 0; i < 300; i++) begin
            r = $urandom_range(0, 99);
            if (r < 5) begin
                v = 9'($urandom_range(0, 509));
                do_init(v);
            end else if (r < 30) begin
                do_bypass();
            end else begin
                do_dec(1'($urandom), $urandom_range(4, 255), 8);
            end
        end

        repeat (3) tick();
        chk("scoreboard_drain", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
